// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared definitions for the SPI transfer sequencer: FSM state encoding and
// default sizing that must track the SPI shift core.
package spi_xfer_ctrl_pkg;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_AW     = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CAPTURE   = 3'd4
    } xfer_state_e;

    function automatic logic state_active(input xfer_state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Host streaming and SPI-core strobe signals of the transfer sequencer.
// slave = the sequencer, master = host logic plus the SPI core.
interface spi_xfer_ctrl_if #(parameter int DWIDTH = 8);

    logic              tx_valid;
    logic              tx_ready;
    logic [DWIDTH-1:0] tx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DWIDTH-1:0] rx_data;
    logic              busy;
    logic              core_cs;
    logic              core_wr;
    logic              core_rd;
    logic [DWIDTH-1:0] core_din;
    logic [DWIDTH-1:0] core_dout;
    logic              core_done;

    modport slave (
        input  tx_valid, tx_data, rx_ready, core_dout, core_done,
        output tx_ready, rx_valid, rx_data, busy,
               core_cs, core_wr, core_rd, core_din
    );

    modport master (
        output tx_valid, tx_data, rx_ready, core_dout, core_done,
        input  tx_ready, rx_valid, rx_data, busy,
               core_cs, core_wr, core_rd, core_din
    );

endinterface

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with count-based full/empty flags.
// Storage is cleared on reset so the head reads 0 while empty after reset.
module spi_sync_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              pop,
    output logic [DWIDTH-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    // push while full is only legal when the same cycle pops
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Host-side sequencer for the SPI shift core: TX FIFO -> one core transfer at a
// time -> RX FIFO, with valid/ready back-pressure on both host streams.
//
//  state        | meaning
//  ST_IDLE      | wait for a TX word and a free RX slot
//  ST_ISSUE     | cs/wr strobe for one cycle with din = TX head, pop TX
//  ST_WAIT_ACK  | wait for core done to drop (discard stale done)
//  ST_WAIT_DONE | wait for core done to rise
//  ST_CAPTURE   | push core dout into RX
module spi_xfer_ctrl
    import spi_xfer_ctrl_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = DEF_AW
) (
    input logic           clk,
    input logic           rst_n,
    spi_xfer_ctrl_if.slave bus
);

    xfer_state_e       state;
    xfer_state_e       state_nxt;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_full;
    logic              rx_empty;
    logic              tx_push;
    logic              tx_pop;
    logic              rx_push;
    logic              rx_pop;
    logic [DWIDTH-1:0] tx_head;

    assign tx_push = bus.tx_valid && !tx_full;
    assign rx_pop  = bus.rx_ready && !rx_empty;
    assign tx_pop  = (state == ST_ISSUE);
    assign rx_push = (state == ST_CAPTURE);

    spi_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .wdata (bus.tx_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    spi_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .wdata (bus.core_dout),
        .pop   (rx_pop),
        .rdata (bus.rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // issuing only with a free RX slot means CAPTURE can never overflow RX
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (!tx_empty && !rx_full) state_nxt = ST_ISSUE;
            ST_ISSUE:     state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (!bus.core_done) state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.core_done) state_nxt = ST_CAPTURE;
            ST_CAPTURE:   state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    assign bus.tx_ready = !tx_full;
    assign bus.rx_valid = !rx_empty;
    assign bus.busy     = state_active(state) || !tx_empty;
    assign bus.core_cs  = (state == ST_ISSUE);
    assign bus.core_wr  = (state == ST_ISSUE);
    assign bus.core_rd  = 1'b0;
    assign bus.core_din = tx_head;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: behavioural SPI core plus queue-based reference of
// the word stream (each accepted word is issued in order and returns inverted).
module tb_spi_xfer_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_xfer_ctrl_if #(.DWIDTH(8)) bus ();

    spi_xfer_ctrl #(.DWIDTH(8), .DEPTH(4), .AW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr = 0;
    int n_rx = 0;
    logic [7:0] wr_q[$];
    logic [7:0] rx_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // behavioural core: done drops one cycle after wr, rises 40 cycles later
    logic       core_stall = 1'b0;
    logic [7:0] core_lat = 8'h00;
    int         core_phase = 0;
    int         core_cnt = 0;

    initial begin
        bus.core_done = 1'b1;
        bus.core_dout = 8'h00;
    end

    always @(posedge clk) begin
        if (bus.core_cs && bus.core_wr) begin
            core_lat   <= bus.core_din;
            core_phase <= 1;
        end else if (core_phase == 1) begin
            bus.core_done <= 1'b0;
            core_cnt      <= 40;
            core_phase    <= 2;
        end else if (core_phase == 2 && !core_stall) begin
            if (core_cnt == 1) begin
                bus.core_done <= 1'b1;
                bus.core_dout <= ~core_lat;
                core_phase    <= 0;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // inputs change at posedge+1, so the negedge view is what the next edge uses
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.core_cs && bus.core_wr) begin
                n_wr++;
                if (wr_q.size() == 0) check_val("wr_unexpected", 32'd1, 32'd0);
                else check_val("wr_din", {24'd0, bus.core_din}, {24'd0, wr_q.pop_front()});
            end
            if (bus.rx_valid && bus.rx_ready) begin
                n_rx++;
                if (rx_q.size() == 0) check_val("rx_unexpected", 32'd1, 32'd0);
                else check_val("rx_data", {24'd0, bus.rx_data}, {24'd0, rx_q.pop_front()});
            end
            if (bus.tx_valid && bus.tx_ready) begin
                wr_q.push_back(bus.tx_data);
                rx_q.push_back(~bus.tx_data);
            end
        end
    end

    // caller is at posedge+1; returns at posedge+1 right after acceptance
    task automatic push_word(input logic [7:0] w);
        bit taken = 0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = w;
        for (int i = 0; i < 3000 && !taken; i++) begin
            @(negedge clk);
            taken = bus.tx_ready;
            @(posedge clk);
            #1;
        end
        if (!taken) check_val("push_timeout", 32'd0, 32'd1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            ok = !bus.busy && !bus.rx_valid;
        end
        if (!ok) check_val("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int wr0;
    int rx0;
    logic [7:0] w;
    bit ok;

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.rx_ready = 1'b0;
        rst_n = 1'b0;

        // reset values
        wait_cycles(3);
        @(negedge clk);
        check_val("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check_val("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_cs_wr_rd", {29'd0, bus.core_cs, bus.core_wr, bus.core_rd}, 32'd0);
        check_val("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(2);

        // single word, held in RX until inspected
        wr0 = n_wr;
        push_word(8'hA5);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.rx_valid;
        end
        check_val("single_rx_valid", {31'd0, ok}, 32'd1);
        check_val("single_rx_data", {24'd0, bus.rx_data}, 32'h5A);
        check_val("single_wr_count", n_wr - wr0, 32'd1);
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b1;
        wait_drain();

        // burst
        wr0 = n_wr;
        rx0 = n_rx;
        for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
        wait_drain();
        check_val("burst_wr_count", n_wr - wr0, 32'd4);
        check_val("burst_rx_count", n_rx - rx0, 32'd4);

        // TX full while the core is stuck on the first word
        core_stall = 1'b1;
        wr0 = n_wr;
        push_word(8'h11);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (n_wr != wr0);
        end
        check_val("full_first_issue", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h3C;
        @(negedge clk);
        check_val("full_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
        wait_cycles(5);
        @(negedge clk);
        check_val("full_tx_ready_hold", {31'd0, bus.tx_ready}, 32'd0);
        @(posedge clk);
        #1;
        core_stall = 1'b0;
        push_word(8'h3C);
        wait_drain();
        check_val("full_wr_count", n_wr - wr0, 32'd6);

        // RX back-pressure: 4 captured, FSM holds with 2 words in TX
        bus.rx_ready = 1'b0;
        wr0 = n_wr;
        rx0 = n_rx;
        for (int i = 0; i < 6; i++) push_word(8'($urandom));
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = (n_wr - wr0 == 4) && !bus.core_cs && bus.core_done && bus.rx_valid;
        end
        wait_cycles(100);
        @(negedge clk);
        check_val("bp_wr_count", n_wr - wr0, 32'd4);
        check_val("bp_busy", {31'd0, bus.busy}, 32'd1);
        check_val("bp_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b1;
        wait_drain();
        check_val("bp_wr_total", n_wr - wr0, 32'd6);
        check_val("bp_rx_total", n_rx - rx0, 32'd6);

        // randomized traffic with random host back-pressure
        wr0 = n_wr;
        rx0 = n_rx;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    push_word(8'($urandom));
                    wait_cycles($urandom_range(0, 30));
                end
            end
            begin
                for (int i = 0; i < 1500; i++) begin
                    @(posedge clk);
                    #1;
                    bus.rx_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.rx_ready = 1'b1;
        wait_drain();
        check_val("rand_wr_count", n_wr - wr0, 32'd24);
        check_val("rand_rx_count", n_rx - rx0, 32'd24);

        // reset while waiting for the core to finish
        push_word(8'h77);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = !bus.core_done && (core_phase == 2);
        end
        check_val("mid_reached_wait", {31'd0, ok}, 32'd1);
        wait_cycles(3);
        rst_n = 1'b0;
        wr_q.delete();
        rx_q.delete();
        #1;
        check_val("mid_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check_val("mid_busy", {31'd0, bus.busy}, 32'd0);
        check_val("mid_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check_val("mid_cs_wr", {30'd0, bus.core_cs, bus.core_wr}, 32'd0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(60);
        @(negedge clk);
        check_val("mid_core_done_seen", {31'd0, bus.core_done}, 32'd1);
        check_val("mid_no_rx_push", {31'd0, bus.rx_valid}, 32'd0);
        check_val("mid_idle", {31'd0, bus.busy}, 32'd0);

        check_val("end_wr_q_empty", wr_q.size(), 32'd0);
        check_val("end_rx_q_empty", rx_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
